// File: rtl/seq_shiftadd_mult.sv
// seq_shiftadd_mult: iterative shift-add multiplier, one multiplier bit per lane per cycle,
// signed/unsigned operands and a two-lane halved-precision mode.
module seq_shiftadd_mult #(
    parameter int WIDTH = 8,
    localparam int PW = 2 * WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic            halved_precision,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PW-1:0]   product
);
    localparam int H = WIDTH / 2;
    localparam int CW = $clog2(WIDTH);

    if (WIDTH % 2 != 0 || WIDTH < 4) begin : gBadWidth
        $error("seq_shiftadd_mult: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT           state;
    logic [PW-1:0]   accum;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic            aSigned;
    logic            bSigned;
    logic            halved;

    logic [PW-1:0]   extA;
    logic [PW-1:0]   fullNext;
    logic [PW-1:0]   halfNext;
    logic [PW-1:0]   nextAcc;
    logic [CW-1:0]   hiIdx;
    logic            laneSub;
    logic            lastBit;

    // One lane step: the H-bit lane operand is extended to WIDTH so lanes wrap independently.
    function automatic logic [WIDTH-1:0] laneStep(
        input logic [WIDTH-1:0] accIn,
        input logic [H-1:0]     a,
        input logic             bitSet,
        input logic             sgnA,
        input logic             sub,
        input logic [CW-1:0]    sh
    );
        logic [WIDTH-1:0] term;
        term = (sgnA ? {{H{a[H-1]}}, a} : {{H{1'b0}}, a}) << sh;
        return !bitSet ? accIn : sub ? accIn - term : accIn + term;
    endfunction

    always_comb begin
        extA = aSigned ? {{WIDTH{aReg[WIDTH-1]}}, aReg} : {{WIDTH{1'b0}}, aReg};
        fullNext = !bReg[count] ? accum
                 : (bSigned && count == CW'(WIDTH-1)) ? accum - (extA << count)
                 : accum + (extA << count);
        hiIdx = CW'(H) + count;
        laneSub = bSigned && count == CW'(H-1);
        halfNext = {laneStep(accum[PW-1:WIDTH], aReg[WIDTH-1:H], bReg[hiIdx], aSigned, laneSub, count),
                    laneStep(accum[WIDTH-1:0], aReg[H-1:0], bReg[count], aSigned, laneSub, count)};
        nextAcc = halved ? halfNext : fullNext;
        lastBit = count == (halved ? CW'(H-1) : CW'(WIDTH-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            accum     <= '0;
            count     <= '0;
            aReg      <= '0;
            bReg      <= '0;
            aSigned   <= 1'b0;
            bSigned   <= 1'b0;
            halved    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    aReg     <= multiplicand;
                    bReg     <= multiplier;
                    aSigned  <= a_signed;
                    bSigned  <= b_signed;
                    halved   <= halved_precision;
                    accum    <= '0;
                    count    <= '0;
                    in_ready <= 1'b0;
                    state    <= BUSY;
                end
                BUSY: begin
                    accum <= nextAcc;
                    count <= count + 1'b1;
                    if (lastBit) begin
                        product   <= nextAcc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shiftadd_mult.sv
// tb_seq_shiftadd_mult: scoreboard bench for seq_shiftadd_mult (WIDTH=8) with an
// independent multiplication model.
module tb_seq_shiftadd_mult;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        a_signed = 1'b0;
    logic        b_signed = 1'b0;
    logic        halved_precision = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;

    int checks = 0;
    int failures = 0;
    logic [15:0] sb[$];

    seq_shiftadd_mult #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .a_signed(a_signed), .b_signed(b_signed), .halved_precision(halved_precision),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic as, input logic bs, input logic hp);
        int x, y;
        logic [31:0] p0, p1;
        if (!hp) begin
            x = as ? int'($signed(a)) : int'(a);
            y = bs ? int'($signed(b)) : int'(b);
            p0 = x * y;
            return p0[15:0];
        end
        x = as ? int'($signed(a[3:0])) : int'(a[3:0]);
        y = bs ? int'($signed(b[3:0])) : int'(b[3:0]);
        p0 = x * y;
        x = as ? int'($signed(a[7:4])) : int'(a[7:4]);
        y = bs ? int'($signed(b[7:4])) : int'(b[7:4]);
        p1 = x * y;
        return {p1[7:0], p0[7:0]};
    endfunction

    // Scoreboard side: compare on each retiring handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_unexpected", 32'(1), 32'(0));
            else check("product", 32'(product), 32'(sb.pop_front()));
        end
    end

    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic as,
                         input logic bs, input logic hp, input int hold);
        int n;
        logic sawReady;
        logic [15:0] exp, held;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'(1));
        multiplicand = a; multiplier = b;
        a_signed = as; b_signed = bs; halved_precision = hp;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        exp = model(a, b, as, bs, hp);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        // Junk operands and a held in_valid while busy must be ignored.
        multiplicand = 8'($urandom); multiplier = 8'($urandom);
        a_signed = ~as; b_signed = ~bs; halved_precision = ~hp;
        n = 0;
        sawReady = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (in_ready) sawReady = 1'b1;
        end while (!out_valid && n < 40);
        in_valid = 1'b0;
        check("latency", n, hp ? 32'(4) : 32'(8));
        check("in_ready_busy", 32'(sawReady), 32'(0));
        if (hold > 0) begin
            held = product;
            check("held_value", 32'(held), 32'(exp));
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                @(posedge clk);
                #1;
                check("bp_stable", {14'(0), out_valid, in_ready, product}, {14'(0), 1'b1, 1'b0, held});
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("retired", 32'(out_valid), 32'(0));
        check("product_kept", 32'(product), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {29'(0), in_ready, out_valid, 1'b0}, {29'(0), 1'b1, 1'b0, 1'b0});
        check("reset_product", 32'(product), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        runOp(8'hFF, 8'hFF, 0, 0, 0, 0);
        runOp(8'h80, 8'h80, 1, 1, 0, 0);
        runOp(8'hFF, 8'h7F, 1, 1, 0, 0);
        runOp(8'hFE, 8'hFF, 1, 0, 0, 0);
        runOp(8'hFF, 8'hFE, 0, 1, 0, 0);
        runOp(8'h87, 8'h83, 1, 1, 1, 0);
        runOp(8'hFF, 8'hFF, 0, 0, 1, 0);
        runOp(8'h3C, 8'h5A, 0, 0, 0, 5);
        runOp(8'h9D, 8'hB6, 1, 1, 1, 3);

        // Reset three cycles into BUSY discards the operation.
        @(negedge clk);
        multiplicand = 8'h12; multiplier = 8'h34;
        a_signed = 0; b_signed = 0; halved_precision = 0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midop_reset", {14'(0), in_ready, out_valid, product}, {14'(0), 1'b1, 1'b0, 16'h0000});
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_pulse_after_reset", 32'(seen), 32'(0));
        runOp(8'h05, 8'h03, 0, 0, 0, 0);
        check("after_reset_value", 32'(product), 32'(16'h000F));

        for (int k = 0; k < 20; k++)
            runOp(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);

        check("sb_drained", sb.size(), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_shiftadd_mult.md
Name: seq_shiftadd_mult

Overview:
- Iterative, parametrised shift-add multiplier; sequential successor to the 4-bit combinational configurable shift-adder.
- Generalised to WIDTH-bit operands, with per-operand signed/unsigned selection and a halved-precision SIMD mode (two independent WIDTH/2 lanes).
- Retires one multiplier bit per lane per cycle and uses a valid/ready handshake on both sides.
- Sits in the PE datapath where area matters more than throughput.

Parameters:
- WIDTH, 8, operand width; must be even and >= 4 (elaboration-time $error otherwise).
- PW, 2*WIDTH, product width; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept operands.
- multiplicand  in  WIDTH  operand A.
- multiplier  in  WIDTH  operand B; its bits are consumed LSB first.
- a_signed  in  1  A is two's complement (sign-extend); else zero-extend.
- b_signed  in  1  B is two's complement (MSB partial product is subtracted); else added.
- halved_precision  in  1  two independent H=WIDTH/2 lanes.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  PW  result.

Behaviour:
- Reset (async assert):
  - state=IDLE; in_ready=1; out_valid=0.
  - product, accumulator, step counter and latched operands/mode all 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch operands, a_signed, b_signed, halved_precision; clear accumulator; counter=0; go to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each cycle, process bit i=counter of the multiplier (per lane in halved mode).
  - Bit i set: add (extended multiplicand << i) to the accumulator.
  - Exception: i is the lane's MSB and b_signed=1, then subtract instead of add.
  - Counter increments each cycle. After the last bit (i=WIDTH-1, or H-1 in halved mode), go to DONE.
- DONE:
  - out_valid=1; product = accumulator; product is held stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid=0 next cycle. product keeps its last value.
  - in_ready stays 0 in DONE, so there is no same-cycle accept/retire overlap.
- Latency: with accept at edge t, out_valid is high after edge t+WIDTH (full) or t+H (halved).
- Throughput: one operation per WIDTH+2 cycles (full) or H+2 (halved), with out_ready held high.
- Full-mode arithmetic:
  - Multiplicand is extended to PW (sign-extended if a_signed, else zero-extended).
  - Accumulator is PW bits and wraps modulo 2^PW.
  - The result equals the exact product for all signedness combinations (fits in PW bits).
- Halved-mode arithmetic:
  - lane0 = A[H-1:0]*B[H-1:0]; lane1 = A[WIDTH-1:H]*B[WIDTH-1:H].
  - Each lane has its own WIDTH-bit accumulator slice, with extension at H bits.
  - There is no carry or borrow between lanes.
  - product = {lane1[WIDTH-1:0], lane0[WIDTH-1:0]}.
  - Signedness flags apply identically to both lanes.
- Mode and signedness are sampled only at accept; input changes during BUSY/DONE have no effect.
- Reset mid-operation: immediate return to IDLE; any in-flight result is discarded with no out_valid pulse.
- Simultaneous in_valid and out_ready in DONE: only the retire happens; the input is accepted at the earliest one cycle later, in IDLE.

Test Plan:
- Unsigned full, WIDTH=8: A=0xFF, B=0xFF, both flags 0 -> product=0xFE01; out_valid 8 cycles after accept; in_ready=0 throughout.
- Signed full: A=0x80, B=0x80, both flags 1 -> 0x4000. Then A=0xFF, B=0x7F -> 0xFF81 (-127).
- Mixed sign: A=0xFE (a_signed=1), B=0xFF (b_signed=0) -> 0xFE02 (-510). Swapped flags, A=0xFF (a_signed=0), B=0xFE (b_signed=1) -> 0xFE02.
- Halved signed: A=0x87, B=0x83, both flags 1 -> lane1=(-8)*(-8)=0x40, lane0=7*3=0x15, product=0x4015; out_valid 4 cycles after accept; no inter-lane carry.
- Backpressure/ignore: hold out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0; in_valid pulses during BUSY/DONE are not accepted. The next op result is independent of those pulses.
- Reset mid-op: assert rst 3 cycles into BUSY -> out_valid=0, product=0, in_ready=1 immediately. The next op (0x05*0x03, unsigned) returns 0x000F.
